ghash_tag_engine: RTL and testbench

Parametrised, multi-channel GHASH accumulator and tag finaliser for the AES-GCM datapath. It keeps independent GHASH state for NUM_CH interleaved GCM instances. Each accepted AAD or ciphertext block is folded into its channel's state with a digit-serial GF(2^128) multiplier that consumes DIGIT_BITS bits of the operand per cycle. On the length block, the channel's tag (S XOR E(K,J0)) is emitted. It sits after the final AES round stage and replaces the single-instance, single-cycle-multiply tag stage.

---
 rtl/ghash_tag_engine.sv | 130 +++++++++++++
 tb/tb_ghash_tag_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ghash_tag_engine.sv
// Multi-channel GHASH accumulator and GCM tag finaliser with a digit-serial GF(2^128) multiplier.
// Data blocks occupy the engine for N = 128/DIGIT_BITS cycles; o_ready drops while a multiply runs.
module ghash_tag_engine #(
  parameter int DIGIT_BITS = 8,
  parameter int NUM_CH = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [CH_W-1:0] i_ch,
  input  logic [1:0]      i_type,
  input  logic [0:127]    i_block,
  input  logic [0:127]    i_h,
  input  logic [0:127]    i_encrypted_j0,
  output logic            o_tag_valid,
  output logic [0:127]    o_tag,
  output logic [CH_W-1:0] o_tag_ch,
  output logic            o_err
);
  localparam int N = 128 / DIGIT_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [1:0] T_LEN = 2'b10;
  localparam logic [1:0] T_START = 2'b11;
  localparam logic [0:127] R_POLY = {8'he1, 120'd0};

  typedef enum logic {IDLE, MULT} state_t;
  state_t state, state_nxt;

  logic [0:127]      s_q [NUM_CH];
  logic [0:127]      h_q [NUM_CH];
  logic [0:127]      j0_q [NUM_CH];
  logic [NUM_CH-1:0] active_q;

  logic [0:127]      x_q, v_q, z_q;
  logic [0:127]      x_nxt, v_nxt, z_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic              len_q;

  logic accept, ch_ok, start_go, data_go, drop, done;

  assign o_ready  = (state == IDLE) && !rst;
  assign accept   = i_valid && o_ready;
  assign ch_ok    = int'(i_ch) < NUM_CH;
  assign start_go = accept && ch_ok && (i_type == T_START);
  assign data_go  = accept && ch_ok && (i_type != T_START) && active_q[i_ch];
  assign drop     = accept && !start_go && !data_go;
  assign done     = (state == MULT) && (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_go) state_nxt = MULT;
      MULT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One digit of SP 800-38D Algorithm 1: consume X bits from index 0 upward.
  always_comb begin
    z_nxt = z_q;
    v_nxt = v_q;
    for (int i = 0; i < DIGIT_BITS; i++) begin
      if (x_q[i]) z_nxt = z_nxt ^ v_nxt;
      v_nxt = (v_nxt >> 1) ^ (v_nxt[127] ? R_POLY : '0);
    end
    x_nxt = x_q << DIGIT_BITS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s_q[c]  <= '0;
        h_q[c]  <= '0;
        j0_q[c] <= '0;
      end
      active_q    <= '0;
      x_q         <= '0;
      v_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      ch_q        <= '0;
      len_q       <= 1'b0;
      o_tag_valid <= 1'b0;
      o_tag       <= '0;
      o_tag_ch    <= '0;
      o_err       <= 1'b0;
    end else begin
      o_tag_valid <= 1'b0;
      o_err       <= drop;
      if (start_go) begin
        s_q[i_ch]      <= '0;
        h_q[i_ch]      <= i_h;
        j0_q[i_ch]     <= i_encrypted_j0;
        active_q[i_ch] <= 1'b1;
      end
      if (data_go) begin
        x_q   <= s_q[i_ch] ^ i_block;
        v_q   <= h_q[i_ch];
        z_q   <= '0;
        cnt_q <= '0;
        ch_q  <= i_ch;
        len_q <= (i_type == T_LEN);
      end
      if (state == MULT) begin
        x_q   <= x_nxt;
        v_q   <= v_nxt;
        z_q   <= z_nxt;
        cnt_q <= cnt_q + 1'b1;
        if (done) begin
          s_q[ch_q] <= z_nxt;
          // The length block closes the message: emit the tag and retire the channel.
          if (len_q) begin
            o_tag          <= z_nxt ^ j0_q[ch_q];
            o_tag_ch       <= ch_q;
            o_tag_valid    <= 1'b1;
            active_q[ch_q] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ghash_tag_engine.sv
// Bench for ghash_tag_engine: three instances (DIGIT_BITS 1, 8, 128) checked against a
// carry-less-multiply-and-reduce GHASH model.
module tb_ghash_tag_engine;
  localparam int LIMIT = 400;
  localparam logic [1:0] AAD = 2'b00, CT = 2'b01, LEN = 2'b10, START = 2'b11;
  localparam logic [127:0] KH   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] KJ0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] KC   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] KLEN = 128'h00000000000000000000000000000080;
  localparam logic [127:0] KT2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   vld;
  logic [1:0]   ch, ty;
  logic [127:0] blk, hk, j0;
  logic         rdy [3];
  logic         tvld [3];
  logic         err [3];
  logic [127:0] tag [3];
  logic [1:0]   tch [3];

  int checks = 0;
  int errors = 0;

  ghash_tag_engine #(.DIGIT_BITS(1), .NUM_CH(4)) u_d1 (
    .clk(clk), .rst(rst), .i_valid(vld[0]), .o_ready(rdy[0]), .i_ch(ch), .i_type(ty),
    .i_block(blk), .i_h(hk), .i_encrypted_j0(j0), .o_tag_valid(tvld[0]), .o_tag(tag[0]),
    .o_tag_ch(tch[0]), .o_err(err[0]));
  ghash_tag_engine #(.DIGIT_BITS(8), .NUM_CH(4)) u_d8 (
    .clk(clk), .rst(rst), .i_valid(vld[1]), .o_ready(rdy[1]), .i_ch(ch), .i_type(ty),
    .i_block(blk), .i_h(hk), .i_encrypted_j0(j0), .o_tag_valid(tvld[1]), .o_tag(tag[1]),
    .o_tag_ch(tch[1]), .o_err(err[1]));
  ghash_tag_engine #(.DIGIT_BITS(128), .NUM_CH(4)) u_d128 (
    .clk(clk), .rst(rst), .i_valid(vld[2]), .o_ready(rdy[2]), .i_ch(ch), .i_type(ty),
    .i_block(blk), .i_h(hk), .i_encrypted_j0(j0), .o_tag_valid(tvld[2]), .o_tag(tag[2]),
    .o_tag_ch(tch[2]), .o_err(err[2]));

  // GCM bit 0 is the x^0 coefficient; flip into polynomial order for the model.
  function automatic logic [127:0] refl(input logic [127:0] a);
    logic [127:0] r;
    for (int j = 0; j < 128; j++) r[j] = a[127-j];
    return r;
  endfunction

  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ca, cb;
    logic [254:0] p;
    ca = refl(a);
    cb = refl(b);
    p = '0;
    for (int i = 0; i < 128; i++)
      if (ca[i]) p = p ^ ({127'd0, cb} << i);
    for (int j = 254; j >= 128; j--)
      if (p[j]) begin
        p[j] = 1'b0;
        p[j-121] = ~p[j-121];
        p[j-126] = ~p[j-126];
        p[j-127] = ~p[j-127];
        p[j-128] = ~p[j-128];
      end
    return refl(p[127:0]);
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Returns at the falling edge of the cycle after acceptance.
  task automatic send(input int k, input logic [1:0] t, input int c, input logic [127:0] b,
                      input logic [127:0] h, input logic [127:0] jj);
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy[k] && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    chk("rdy_timeout", 128'(w >= LIMIT), 128'(0));
    ch = 2'(c); ty = t; blk = b; hk = h; j0 = jj;
    vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
  endtask

  task automatic wait_tag(input int k, input logic [127:0] exp_tag, input int exp_ch,
                          input int exp_lat, input string nm);
    int c;
    c = 1;
    while (!tvld[k] && c < LIMIT) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_tag"}, tag[k], exp_tag);
    chk({nm, "_ch"}, 128'(tch[k]), 128'(exp_ch));
    chk({nm, "_latency"}, 128'(c), 128'(exp_lat));
    @(negedge clk);
    chk({nm, "_pulse_len"}, 128'(tvld[k]), 128'(0));
    chk({nm, "_hold"}, tag[k], exp_tag);
  endtask

  logic [127:0] ms [4];
  logic [127:0] mh [4];
  logic [127:0] mj [4];
  logic         mact [4];
  int           nk, rc, seen;
  logic [1:0]   rt;
  logic [127:0] rb, rh, rj;

  initial begin
    rst = 1'b1; vld = '1; ty = LEN; ch = '0; blk = '0; hk = '0; j0 = '0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("rst_ready", 128'(rdy[k]), 128'(0));
        chk("rst_tag_valid", 128'(tvld[k]), 128'(0));
        chk("rst_err", 128'(err[k]), 128'(0));
      end
    end
    rst = 1'b0; vld = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_ready", 128'(rdy[k]), 128'(1));
      chk("post_rst_tag", tag[k], 128'(0));
      chk("post_rst_tag_ch", 128'(tch[k]), 128'(0));
    end

    // Known-answer vectors, then two channels interleaved.
    for (int k = 0; k < 3; k++) begin
      nk = (k == 0) ? 128 : (k == 1) ? 16 : 1;
      send(k, START, 0, '0, KH, KJ0);
      chk("start_no_err", 128'(err[k]), 128'(0));
      send(k, LEN, 0, '0, '0, '0);
      wait_tag(k, KJ0, 0, nk + 1, "tc1");
      send(k, START, 0, '0, KH, KJ0);
      send(k, CT, 0, KC, '0, '0);
      send(k, LEN, 0, KLEN, '0, '0);
      wait_tag(k, KT2, 0, nk + 1, "tc2");
      send(k, START, 1, '0, KH, KJ0);
      send(k, START, 3, '0, KH, KJ0);
      send(k, CT, 1, KC, '0, '0);
      send(k, LEN, 3, '0, '0, '0);
      wait_tag(k, KJ0, 3, nk + 1, "ilv_ch3");
      send(k, LEN, 1, KLEN, '0, '0);
      wait_tag(k, KT2, 1, nk + 1, "ilv_ch1");
    end

    send(1, CT, 2, KC, '0, '0);
    chk("err_unstarted", 128'(err[1]), 128'(1));
    chk("err_ready", 128'(rdy[1]), 128'(1));
    @(negedge clk);
    chk("err_one_cycle", 128'(err[1]), 128'(0));
    send(1, LEN, 2, '0, '0, '0);
    chk("err_still_inactive", 128'(err[1]), 128'(1));
    send(1, LEN, 0, '0, '0, '0);
    chk("err_len_after_tag", 128'(err[1]), 128'(1));

    // Random command streams over four channels.
    for (int k = 0; k < 3; k++) begin
      nk = (k == 0) ? 128 : (k == 1) ? 16 : 1;
      for (int c = 0; c < 4; c++) mact[c] = 1'b0;
      for (int it = 0; it < 40; it++) begin
        rc = $urandom_range(0, 3);
        rb = {$urandom, $urandom, $urandom, $urandom};
        if (!mact[rc] && $urandom_range(0, 3) == 0) begin
          send(k, CT, rc, rb, '0, '0);
          chk("rnd_drop_err", 128'(err[k]), 128'(1));
        end else if (!mact[rc] || $urandom_range(0, 7) == 0) begin
          rh = {$urandom, $urandom, $urandom, $urandom};
          rj = {$urandom, $urandom, $urandom, $urandom};
          send(k, START, rc, rb, rh, rj);
          chk("rnd_start_err", 128'(err[k]), 128'(0));
          ms[rc] = '0; mh[rc] = rh; mj[rc] = rj; mact[rc] = 1'b1;
        end else begin
          rt = ($urandom_range(0, 3) == 0) ? LEN : 2'($urandom_range(0, 1));
          send(k, rt, rc, rb, '0, '0);
          chk("rnd_data_err", 128'(err[k]), 128'(0));
          ms[rc] = gf_mul(ms[rc] ^ rb, mh[rc]);
          if (rt == LEN) begin
            mact[rc] = 1'b0;
            wait_tag(k, ms[rc] ^ mj[rc], rc, nk + 1, "rnd");
          end
        end
      end
    end

    // Reset in the second cycle of a multiply.
    send(1, START, 0, '0, KH, KJ0);
    send(1, LEN, 0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      if (tvld[1]) seen = 1;
      @(negedge clk);
    end
    chk("rst_mid_no_tag", 128'(seen), 128'(0));
    chk("rst_mid_tag_cleared", tag[1], 128'(0));
    send(1, LEN, 0, '0, '0, '0);
    chk("rst_mid_len_err", 128'(err[1]), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
